// File: rtl/spi_master_core.sv
// SPI mode-0 master: shifts one DATA_WIDTH word out on mosi (MSB first)
// while capturing miso, with cs held high for one half-period after each word.
module spi_master_core #(
    parameter int DATA_WIDTH      = 32,
    parameter int SCLK_HALFPERIOD = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_transaction,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  miso,
    output logic                  mosi,
    output logic                  sclk,
    output logic                  cs,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  ready
);

    localparam int CW = (SCLK_HALFPERIOD > 1) ? $clog2(SCLK_HALFPERIOD) : 1;
    localparam int BW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] HLAST = CW'(SCLK_HALFPERIOD - 1);
    localparam logic [BW-1:0] BLAST = BW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        TRANSFER,
        CS_HOLD
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [DATA_WIDTH-1:0] tx_q, tx_d;
    logic [DATA_WIDTH-1:0] rx_q, rx_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  sclk_q, sclk_d;
    logic                  cs_q, cs_d;
    logic                  ready_q, ready_d;
    logic                  tc;

    assign tc = (cnt_q == HLAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            dout_q  <= '0;
            sclk_q  <= 1'b0;
            cs_q    <= 1'b1;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            dout_q  <= dout_d;
            sclk_q  <= sclk_d;
            cs_q    <= cs_d;
            ready_q <= ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        dout_d  = dout_q;
        sclk_d  = sclk_q;
        cs_d    = cs_q;
        ready_d = ready_q;
        unique case (state_q)
            IDLE: begin
                if (start_transaction) begin
                    tx_d    = data_in;
                    rx_d    = '0;
                    cnt_d   = '0;
                    bit_d   = '0;
                    cs_d    = 1'b0;
                    ready_d = 1'b0;
                    state_d = TRANSFER;
                end
            end
            TRANSFER: begin
                if (tc) begin
                    cnt_d  = '0;
                    sclk_d = ~sclk_q;
                    if (!sclk_q) begin
                        rx_d = {rx_q[DATA_WIDTH-2:0], miso};
                    end else if (bit_q != BLAST) begin
                        bit_d = bit_q + 1'b1;
                        tx_d  = {tx_q[DATA_WIDTH-2:0], 1'b0};
                    end else begin
                        // rx_q already holds the bit taken on the last rise
                        dout_d  = rx_q;
                        tx_d    = '0;
                        cs_d    = 1'b1;
                        state_d = CS_HOLD;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CS_HOLD: begin
                if (tc) begin
                    cnt_d   = '0;
                    ready_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // mosi is the TX MSB; tx_q is zero whenever the core is idle
    assign mosi     = tx_q[DATA_WIDTH-1];
    assign sclk     = sclk_q;
    assign cs       = cs_q;
    assign ready    = ready_q;
    assign data_out = dout_q;

endmodule

// File: tb/tb_spi_master_core.sv
// Directed bench for spi_master_core (W=32, H=8): timing, data, reset,
// ignored starts and back-to-back transfers.
module tb_spi_master_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] data_in;
    logic        miso;
    logic        mosi;
    logic        sclk;
    logic        cs;
    logic [31:0] data_out;
    logic        ready;
    int          miso_mode;

    int total = 0;
    int bad   = 0;

    int          rises;
    int          per_bad;
    int          cslow;
    int          csviol;
    logic [31:0] sw;
    time         last_rise;

    spi_master_core dut (
        .clk              (clk),
        .rst              (rst),
        .start_transaction(start),
        .data_in          (data_in),
        .miso             (miso),
        .mosi             (mosi),
        .sclk             (sclk),
        .cs               (cs),
        .data_out         (data_out),
        .ready            (ready)
    );

    always #5 clk = ~clk;

    always_comb begin
        miso = 1'b0;
        if (miso_mode == 0) miso = mosi;
        else if (miso_mode == 1) miso = 1'b1;
    end

    always @(posedge sclk) begin
        if (rises > 0 && ($time - last_rise) != 160) per_bad++;
        last_rise = $time;
        rises++;
        sw = {sw[30:0], mosi};
    end

    always @(negedge clk) begin
        if (cs && sclk) csviol++;
        if (!cs) cslow++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_mon();
        rises   = 0;
        per_bad = 0;
        cslow   = 0;
        sw      = '0;
    endtask

    task automatic run_xfer(input logic [31:0] d, input logic [31:0] exp,
                            input bit pulse_ign);
        int c;
        clr_mon();
        start   = 1'b1;
        data_in = d;
        tick();
        c       = 0;
        start   = 1'b0;
        data_in = ~d;
        chk("cs_fall", cs, 0);
        chk("ready_fall", ready, 0);
        chk("mosi_msb", mosi, d[31]);
        while (c < 7) begin tick(); c++; end
        chk("sclk_pre_rise", sclk, 0);
        tick(); c++;
        chk("sclk_first_rise", sclk, 1);
        if (pulse_ign) begin
            while (c < 99) begin tick(); c++; end
            start   = 1'b1;
            data_in = 32'h5555AAAA;
            tick(); c++;
            start = 1'b0;
            chk("ign_ready", ready, 0);
            chk("ign_cs", cs, 0);
        end
        while (c < 511) begin tick(); c++; end
        chk("cs_before_end", cs, 0);
        tick(); c++;
        chk("data_out", data_out, exp);
        chk("cs_rise", cs, 1);
        chk("mosi_idle", mosi, 0);
        chk("sclk_idle", sclk, 0);
        while (c < 519) begin tick(); c++; end
        chk("ready_early", ready, 0);
        tick(); c++;
        chk("ready_rise", ready, 1);
        chk("rises", rises, 32);
        chk("sclk_period", per_bad, 0);
        chk("cs_low_cycles", cslow, 512);
        chk("slave_word", sw, d);
    endtask

    initial begin
        int c;
        csviol    = 0;
        miso_mode = 0;
        start     = 1'b0;
        data_in   = '0;
        rst       = 1'b1;
        clr_mon();
        tick();
        chk("rst_ready", ready, 1);
        chk("rst_cs", cs, 1);
        chk("rst_sclk", sclk, 0);
        chk("rst_mosi", mosi, 0);
        chk("rst_dout", data_out, 0);
        rst = 1'b0;
        tick();

        run_xfer(32'hA5A50F0F, 32'hA5A50F0F, 1'b0);
        run_xfer(32'h80000001, 32'h80000001, 1'b0);
        miso_mode = 1;
        run_xfer(32'h00000000, 32'hFFFFFFFF, 1'b0);
        miso_mode = 2;
        run_xfer(32'hFFFFFFFF, 32'h00000000, 1'b0);
        miso_mode = 0;
        run_xfer(32'h3C3CC3C3, 32'h3C3CC3C3, 1'b1);
        chk("ign_hold", data_out, 32'h3C3CC3C3);

        start   = 1'b1;
        data_in = 32'h0F1E2D3C;
        tick();
        start = 1'b0;
        c     = 0;
        while (c < 199) begin tick(); c++; end
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_cs", cs, 1);
        chk("mid_rst_sclk", sclk, 0);
        chk("mid_rst_ready", ready, 1);
        chk("mid_rst_dout", data_out, 0);
        chk("mid_rst_mosi", mosi, 0);
        tick();
        rst = 1'b0;
        tick();
        run_xfer(32'hC0FFEE11, 32'hC0FFEE11, 1'b0);

        clr_mon();
        start   = 1'b1;
        data_in = 32'h12345678;
        tick();
        c       = 0;
        data_in = 32'h9ABCDEF0;
        chk("b2b_cs0", cs, 0);
        while (c < 512) begin tick(); c++; end
        chk("b2b_dout0", data_out, 32'h12345678);
        chk("b2b_slave0", sw, 32'h12345678);
        while (c < 520) begin tick(); c++; end
        chk("b2b_ready", ready, 1);
        chk("b2b_gap_cs", cs, 1);
        tick(); c++;
        chk("b2b_cs1", cs, 0);
        chk("b2b_ready1", ready, 0);
        chk("b2b_gap", cslow, 512);
        start = 1'b0;
        c     = 0;
        while (c < 512) begin tick(); c++; end
        chk("b2b_dout1", data_out, 32'h9ABCDEF0);
        chk("b2b_slave1", sw, 32'h9ABCDEF0);
        chk("b2b_rises", rises, 64);
        while (c < 520) begin tick(); c++; end
        chk("b2b_ready_end", ready, 1);
        chk("cs_sclk_idle", csviol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
